// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared types and defaults for the RX packet framer.
// Holds the framer state encoding, default SYNC_BYTE / MAX_LEN, and the
// LEN-byte legality test.
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } rx_state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned DEF_MAX_LEN   = 16;

  // A LEN byte is legal when it is non-zero and does not exceed max_len.
  function automatic logic len_legal(input logic [7:0] b, input logic [7:0] max_len);
    return (b != 8'h00) && (b <= max_len);
  endfunction

endpackage

// File: rtl/rx_byte_timer.sv
// rx_byte_timer: inter-byte timeout counter for rx_pkt_framer.
// Counts enabled cycles since the last restart; 'expired' is asserted on
// the cycle the count reaches TIMEOUT_CYCLES, unless a restart arrives in
// that same cycle (the byte wins).
module rx_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 650_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Cycle counter: cleared while disabled or on restart, saturates at LAST.
  always_ff @(posedge clk_in) begin
    if (rst_in || !enable || restart) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && !restart && (count == LAST);

endmodule

// File: rtl/rx_pkt_framer.sv
// rx_pkt_framer: frames SYNC/LEN/payload/CHK byte streams from a UART
// receiver, verifies the XOR checksum and drains the buffered payload over
// a valid/ready interface.
// Optional feature: define RX_PKT_TIMEOUT_EN to enable the inter-byte
// timeout (rx_byte_timer); otherwise 'timeout' is tied low and a partial
// frame waits indefinitely.
module rx_pkt_framer
  import rx_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 650_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       len_err,
  output logic       chk_err,
  output logic       drop,
  output logic       timeout
);

  localparam int unsigned IW        = $clog2(MAX_LEN + 1);
  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  rx_state_t     state;
  logic [IW-1:0] len;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [7:0]    chk;
  logic [7:0]    pay_buf [DEPTH];
  logic          accept;

  assign accept = pkt_valid && pkt_ready;

`ifdef RX_PKT_TIMEOUT_EN
  logic tmr_enable;
  logic tmr_expired;

  assign tmr_enable = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);

  rx_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .enable (tmr_enable),
    .restart(byte_valid),
    .expired(tmr_expired)
  );
`else
  assign timeout = 1'b0;
`endif

  // Payload storage: written only while collecting payload bytes.
  always_ff @(posedge clk_in) begin
    if (state == ST_PAYLOAD && byte_valid) begin
      pay_buf[wr_idx[AW-1:0]] <= byte_in;
    end
  end

  // The buffer is only observed while draining; rd_idx is held during stalls.
  assign pkt_data = pkt_valid ? pay_buf[rd_idx[AW-1:0]] : '0;

  // Frame FSM with registered handshake outputs and one-cycle error pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      chk       <= '0;
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
      pkt_len   <= '0;
      len_err   <= 1'b0;
      chk_err   <= 1'b0;
      drop      <= 1'b0;
`ifdef RX_PKT_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else begin
      len_err <= 1'b0;
      chk_err <= 1'b0;
      drop    <= 1'b0;
`ifdef RX_PKT_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (byte_valid && byte_in == SYNC_BYTE) begin
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (byte_valid) begin
            if (!len_legal(byte_in, MAX_LEN_B)) begin
              len_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              len    <= byte_in[IW-1:0];
              chk    <= byte_in;
              wr_idx <= '0;
              state  <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_valid) begin
            chk    <= chk ^ byte_in;
            wr_idx <= wr_idx + IW'(1);
            if (wr_idx == len - IW'(1)) begin
              state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (byte_valid) begin
            if (byte_in == chk) begin
              state     <= ST_DRAIN;
              pkt_valid <= 1'b1;
              pkt_len   <= 8'(len);
              pkt_last  <= (len == IW'(1));
              rd_idx    <= '0;
            end else begin
              chk_err <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          drop <= byte_valid;
          if (accept) begin
            if (pkt_last) begin
              state     <= ST_IDLE;
              pkt_valid <= 1'b0;
              pkt_last  <= 1'b0;
              pkt_len   <= '0;
              rd_idx    <= '0;
            end else begin
              rd_idx   <= rd_idx + IW'(1);
              pkt_last <= (rd_idx + IW'(1) == len - IW'(1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef RX_PKT_TIMEOUT_EN
      // Expiry implies an active frame state and no byte this cycle, so it
      // never collides with the case branches above.
      if (tmr_expired) begin
        timeout <= 1'b1;
        state   <= ST_IDLE;
      end
`endif
    end
  end

endmodule

// File: doc/rx_pkt_framer.md
RX_PKT_FRAMER -- requirements
Module: rx_pkt_framer

Interface
REQ-001 Parameters SHALL be:
- MAX_LEN, 16, maximum payload bytes, 1..255.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 650_000, inter-byte timeout in clk_in cycles (10 ms at 65 MHz).

REQ-002 Ports SHALL be:
- clk_in  in  1  sole clock.
- rst_in  in  1  synchronous, active-high reset.
- byte_in  in  8  received byte from the UART receiver.
- byte_valid  in  1  one-cycle strobe qualifying byte_in.
- pkt_data  out  8  payload byte.
- pkt_valid  out  1  pkt_data valid.
- pkt_ready  in  1  consumer accepts pkt_data.
- pkt_last  out  1  final payload byte of the frame.
- pkt_len  out  8  payload length of the frame being drained.
- len_err  out  1  one-cycle pulse: illegal LEN byte.
- chk_err  out  1  one-cycle pulse: checksum mismatch.
- drop  out  1  one-cycle pulse: byte discarded during DRAIN.
- timeout  out  1  one-cycle pulse: inter-byte timeout.

Function
REQ-003 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-004 The FSM SHALL have the states IDLE, LEN, PAYLOAD, CHECK and DRAIN; only byte_valid cycles advance IDLE, LEN, PAYLOAD and CHECK.
REQ-005 IDLE: byte_in==SYNC_BYTE -> LEN; any other byte is ignored silently.
REQ-006 LEN: byte 0 or >MAX_LEN -> len_err pulse, IDLE; otherwise latch the length, chk=byte, write index=0 -> PAYLOAD.
REQ-007 PAYLOAD: buf[idx]=byte, chk^=byte, idx++; after storing byte LEN-1 -> CHECK.
REQ-008 CHECK: byte==chk -> DRAIN; else chk_err pulse -> IDLE, with the buffer discarded.
REQ-009 pkt_valid SHALL assert on the cycle after the CHK strobe (latency 1) and remain high until the last byte is accepted.
REQ-010 DRAIN: pkt_data=buf[rd_idx]; pkt_len=latched LEN; pkt_last=(rd_idx==LEN-1); rd_idx advances only on pkt_valid&&pkt_ready.
REQ-011 pkt_data, pkt_last and pkt_len SHALL be held stable while pkt_valid&&!pkt_ready.
REQ-012 When the last byte is accepted, the FSM -> IDLE and pkt_valid deasserts the next cycle.
REQ-013 A byte_valid during DRAIN SHALL be discarded with a drop pulse; this includes SYNC_BYTE.
REQ-014 An accept and a byte_valid in the same DRAIN cycle SHALL both take effect: the read advances and drop pulses.
REQ-015 Error pulses SHALL be mutually exclusive and one cycle long; the payload buffer SHALL never be read outside DRAIN.
REQ-016 Index and checksum arithmetic SHALL be unsigned, with widths of $clog2(MAX_LEN+1) and 8 bits; no wrap is reachable.

Reset
REQ-017 With rst_in high at a clock edge, the next state SHALL be IDLE.
REQ-018 Reset SHALL clear all outputs to 0: pkt_data, pkt_valid, pkt_last, pkt_len, len_err, chk_err, drop and timeout.
REQ-019 Reset SHALL clear the indices, checksum and timer; buffer contents need not reset.
REQ-020 Reset mid-frame or mid-DRAIN SHALL abandon the frame without any error pulse.

Configuration
REQ-021 With RX_PKT_TIMEOUT_EN defined: in LEN, PAYLOAD or CHECK the timer counts cycles since the last byte_valid.
REQ-022 When the timer reaches TIMEOUT_CYCLES, the block SHALL emit a timeout pulse and return to IDLE; byte_valid resets the timer.
REQ-023 Timeout and byte_valid on the same cycle: the byte SHALL win and no pulse is emitted.
REQ-024 Without RX_PKT_TIMEOUT_EN, no timer logic SHALL exist, the timeout output SHALL be tied 0, and a partial frame waits indefinitely.

Structure
REQ-025 Package rx_pkt_pkg SHALL hold the state enum, the default SYNC_BYTE and the default MAX_LEN.
REQ-026 The timer SHALL be sub-module rx_byte_timer (clk_in, rst_in, enable, restart, expired), instantiated only under RX_PKT_TIMEOUT_EN.

Verification
REQ-027 Good frame: A5,03,11,22,33,03 with pkt_ready=1 -> pkt_valid 1 cycle after CHK; bytes 11,22,33 output; pkt_last on 33; pkt_len=3.
REQ-028 Bad checksum: A5,02,AA,BB,00 -> chk_err pulse, pkt_valid never high, state IDLE.
REQ-029 Bad length: A5,00 -> len_err pulse; A5,11 (17) -> len_err pulse. A following good frame SHALL be received intact.
REQ-030 Backpressure: good 4-byte frame, pkt_ready toggled 1/0 -> pkt_data stable while stalled; a byte 55 injected in DRAIN -> drop pulse and the output sequence is unchanged.
REQ-031 Timeout (RX_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=100): A5,04,01 then idle for 100 cycles -> timeout pulse. Reset asserted mid-PAYLOAD -> all outputs 0, no error pulse, next frame OK.
